level_controller: RTL
=====================

Name: level_controller

Overview:
- Game-flow controller directly upstream of the countdown timer. It generates that timer's enable and reload strobe and consumes its time_up flag.
- Accumulates the player's score from grab events and compares it against a per-level target when time expires.
- Sequences the game: level start, play, level clear / game over / game won.
- Also drives move_enable to the hook/claw logic.

Parameters:
- SCORE_W, 16, score and target width
- LEVEL_W, 4, level counter width
- ADD_W, 8, width of a single score increment
- BASE_TARGET, 100, target score for level 1
- TARGET_STEP, 150, target increase per level
- MAX_LEVEL, 8, final level; clearing it wins the game
- HOLD_W, 26, width of the clear-banner hold counter
- CLEAR_HOLD, 49999999, cycles spent in CLEAR minus one (1 s at 50 MHz)

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous, active-high; forces IDLE and all reset values
- start, in, 1, one-cycle pulse from the debounced start key
- score_add_valid, in, 1, one-cycle pulse: a grabbed item reached the miner
- score_add, in, ADD_W, value of that item; sampled when score_add_valid=1
- time_up, in, 1, from timer: time_remain==0
- timer_enable, out, 1, timer count enable
- time_resetn, out, 1, active-low timer reload strobe
- move_enable, out, 1, hook/claw may move
- score, out, SCORE_W, cumulative score
- target, out, SCORE_W, current level's target
- level, out, LEVEL_W, current level, 1-based
- level_clear, out, 1, high while in CLEAR
- game_over, out, 1, high while in OVER
- game_won, out, 1, high while in WON

Behaviour:
- States: IDLE, LOAD, PLAY, CLEAR, OVER, WON. One registered state.
- Outputs timer_enable, time_resetn, move_enable and the three flags decode combinationally from the state register (Moore outputs).
- Reset values: state=IDLE, score=0, level=1, target=BASE_TARGET, hold counter=0. Outputs: timer_enable=0, time_resetn=0, move_enable=0, all flags 0.
- time_resetn=0 in IDLE and LOAD, 1 elsewhere. timer_enable=1 and move_enable=1 only in PLAY.
- IDLE:
  - start=1 -> LOAD; score<=0, level<=1, target<=BASE_TARGET.
- LOAD:
  - Exactly one cycle, then -> PLAY unconditionally.
  - The timer reloads on the closing edge, so the first PLAY cycle sees time_up=0.
  - time_up is ignored in LOAD.
- PLAY:
  - When score_add_valid=1: score <= min(score+score_add, 2^SCORE_W-1). The add is done at SCORE_W+1 bits and saturates.
  - Increments are accepted only in PLAY; they are dropped in every other state.
  - On time_up=1, compare the post-add score, including any increment accepted that same cycle, against target:
    - score >= target and level == MAX_LEVEL -> WON.
    - score >= target and level < MAX_LEVEL -> CLEAR, hold counter <= 0.
    - score < target -> OVER.
  - start is ignored in PLAY.
- CLEAR:
  - The hold counter increments every cycle.
  - When the counter equals CLEAR_HOLD: level <= level+1, target <= target+TARGET_STEP (saturating at 2^SCORE_W-1), -> LOAD.
  - Score carries across levels.
  - Dwell in CLEAR is exactly CLEAR_HOLD+1 cycles.
- OVER, WON:
  - Terminal until start=1, then -> LOAD with score<=0, level<=1, target<=BASE_TARGET.
  - score and level hold their final values for display until then.
- Reset mid-operation: on the next edge, everything returns to reset values regardless of state. No partial score is retained.
- target is registered and updated incrementally; no multiplier is used.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants (3-bit: IDLE=0, LOAD=1, PLAY=2, CLEAR=3, OVER=4, WON=5)
  - SCORE_W, LEVEL_W, ADD_W defaults
  - BASE_TARGET, TARGET_STEP, MAX_LEVEL defaults
- One sub-module: score_accumulator.
  - Holds the saturating score register: clear, add-valid and add-value inputs.
  - Reused later by the display stage for per-level subtotals.
- The FSM, level/target registers and hold counter stay in level_controller.

Test Plan:
- Reset check: reset=1 for 2 cycles -> state IDLE, score=0, level=1, target=100, time_resetn=0, timer_enable=0, move_enable=0.
- Start and clear (CLEAR_HOLD=3):
  - Stimulus: start pulse; adds of 60 and 50 in PLAY; time_up.
  - Response: LOAD lasts 1 cycle with time_resetn=0; PLAY has timer_enable=1; score=110; time_up -> level_clear for 4 cycles; then level=2, target=250, LOAD, PLAY.
- Fail with same-cycle add: score=90, target=100; score_add_valid with add=10 in the same cycle as time_up -> CLEAR (post-add 100>=100). Rerun with add=9 -> OVER, score=99 held, move_enable=0.
- Saturation and dropped adds:
  - SCORE_W=8, score=250, add 20 -> score=255.
  - score_add_valid in IDLE/CLEAR/OVER -> score unchanged.
- Win: MAX_LEVEL=2, clear level 1 then level 2 -> game_won=1 and level=2 held; start -> LOAD, score=0, level=1, target=100.
- Reset mid-CLEAR: reset during hold counter=1 -> next cycle IDLE, score=0, level=1, level_clear=0; start ignored during PLAY (no LOAD re-entry).

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants for the game-flow controller
//   State encoding (3-bit) plus default widths and level targets.
package game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_CLEAR = 3'd3;
  localparam state_t ST_OVER  = 3'd4;
  localparam state_t ST_WON   = 3'd5;

  localparam int SCORE_W_DEF     = 16;
  localparam int LEVEL_W_DEF     = 4;
  localparam int ADD_W_DEF       = 8;
  localparam int BASE_TARGET_DEF = 100;
  localparam int TARGET_STEP_DEF = 150;
  localparam int MAX_LEVEL_DEF   = 8;

endpackage

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - saturating score register
//   clk_i        system clock
//   reset_i      synchronous active-high reset, score -> 0
//   clear_i      synchronous clear, wins over an add in the same cycle
//   add_valid_i  accept add_i this cycle
//   add_i        increment value
//   score_o      registered score
//   score_next_o value score_o takes on the next edge (post-add)
module score_accumulator
  import game_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int ADD_W   = ADD_W_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               add_valid_i,
  input  logic [ADD_W-1:0]   add_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] score_next_o
);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum;

  // One extra bit catches the carry that signals saturation.
  assign sum = {1'b0, score_q} + {{(SCORE_W + 1 - ADD_W){1'b0}}, add_i};

  always_comb begin
    score_d = score_q;
    if (add_valid_i) begin
      score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end
    if (clear_i) begin
      score_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o      = score_q;
  assign score_next_o = score_d;

endmodule

// File: rtl/level_controller.sv
// rtl/level_controller.sv - game-flow FSM driving the countdown timer
//   clk, reset          clock, synchronous active-high reset
//   start               start-key pulse (honoured in IDLE/OVER/WON)
//   score_add_valid/add grab event and its value (accepted in PLAY only)
//   time_up             timer expired
//   timer_enable        timer counts (PLAY)
//   time_resetn         active-low timer reload (low in IDLE/LOAD)
//   move_enable         hook/claw may move (PLAY)
//   score/target/level  current score, level target, 1-based level
//   level_clear/game_over/game_won  high in CLEAR / OVER / WON
module level_controller
  import game_pkg::*;
#(
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int LEVEL_W     = LEVEL_W_DEF,
  parameter int ADD_W       = ADD_W_DEF,
  parameter int BASE_TARGET = BASE_TARGET_DEF,
  parameter int TARGET_STEP = TARGET_STEP_DEF,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
  parameter int HOLD_W      = 26,
  parameter int CLEAR_HOLD  = 49999999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               score_add_valid,
  input  logic [ADD_W-1:0]   score_add,
  input  logic               time_up,
  output logic               timer_enable,
  output logic               time_resetn,
  output logic               move_enable,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] target,
  output logic [LEVEL_W-1:0] level,
  output logic               level_clear,
  output logic               game_over,
  output logic               game_won
);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SCORE_W-1:0] target_q, target_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SCORE_W:0]   target_sum;
  logic [SCORE_W-1:0] score_next;
  logic               new_game;
  logic               add_en;

  // A new game may only be launched from an idle or finished state.
  assign new_game = start && (state_q == ST_IDLE || state_q == ST_OVER || state_q == ST_WON);
  assign add_en   = score_add_valid && (state_q == ST_PLAY);

  assign target_sum = {1'b0, target_q} + (SCORE_W + 1)'(TARGET_STEP);

  score_accumulator #(
    .SCORE_W (SCORE_W),
    .ADD_W   (ADD_W)
  ) u_score (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (new_game),
    .add_valid_i  (add_en),
    .add_i        (score_add),
    .score_o      (score),
    .score_next_o (score_next)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE, ST_OVER, ST_WON: begin
        if (start) begin
          state_d  = ST_LOAD;
          level_d  = LEVEL_W'(1);
          target_d = SCORE_W'(BASE_TARGET);
        end
      end
      ST_LOAD: state_d = ST_PLAY;
      ST_PLAY: begin
        // Judge on the post-add score so a last-moment grab still counts.
        if (time_up) begin
          if (score_next >= target_q) begin
            if (level_q == LEVEL_W'(MAX_LEVEL)) begin
              state_d = ST_WON;
            end else begin
              state_d = ST_CLEAR;
              hold_d  = '0;
            end
          end else begin
            state_d = ST_OVER;
          end
        end
      end
      ST_CLEAR: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(CLEAR_HOLD)) begin
          state_d  = ST_LOAD;
          level_d  = level_q + LEVEL_W'(1);
          target_d = target_sum[SCORE_W] ? {SCORE_W{1'b1}} : target_sum[SCORE_W-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      level_q  <= LEVEL_W'(1);
      target_q <= SCORE_W'(BASE_TARGET);
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign timer_enable = (state_q == ST_PLAY);
  assign move_enable  = (state_q == ST_PLAY);
  assign time_resetn  = !(state_q == ST_IDLE || state_q == ST_LOAD);
  assign level_clear  = (state_q == ST_CLEAR);
  assign game_over    = (state_q == ST_OVER);
  assign game_won     = (state_q == ST_WON);
  assign level        = level_q;
  assign target       = target_q;

endmodule
